// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard bubble controller:
// FSM encoding, the IF/ID NOP word and the default register-specifier width.
package hazard_bubble_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    BSTALL = 2'd2
  } state_t;

  localparam logic [15:0] NOP_INST  = 16'h0800;
  localparam int          REG_W_DEF = 3;

endpackage

// File: rtl/hazard_bubble_ctrl_stage_reg.sv
// One pipeline-tracking slot {valid, dst, regwrite}; a bubble load clears it
// to the same value as reset.
module hazard_stage_reg
  import hazard_bubble_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bubble,
  input  logic             i_valid,
  input  logic [REG_W-1:0] i_dst,
  input  logic             i_regwrite,
  output logic             o_valid,
  output logic [REG_W-1:0] o_dst,
  output logic             o_regwrite
);

  logic             r_valid;
  logic [REG_W-1:0] r_dst;
  logic             r_regwrite;

  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_valid    <= 1'b0;
      r_dst      <= '0;
      r_regwrite <= 1'b0;
    end else begin
      r_valid    <= i_valid;
      r_dst      <= i_dst;
      r_regwrite <= i_regwrite;
    end
  end

  assign o_valid    = r_valid;
  assign o_dst      = r_dst;
  assign o_regwrite = r_regwrite;

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// Decode-stage hazard bubble controller: tracks EX/MEM/WB destinations and
// drives PC/IF-ID hold, flush and EX bubbles. Optional HAZARD_STALL_CNT_EN adds stall_cnt.
module hazard_bubble_ctrl
  import hazard_bubble_ctrl_pkg::*;
#(
  parameter int BR_BUBBLES = 2,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memwrite,
  input  logic             id_is_branch,
  input  logic             stall_n,
  input  logic             ex_br_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic [REG_W-1:0] ex_dst,
  output logic [REG_W-1:0] mem_dst,
  output logic [REG_W-1:0] wb_dst,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             mem_regwrite,
  output logic             wb_regwrite,
  output logic             ex_memwrite
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  state_t      r_state, w_nextState;
  logic [1:0]  r_brCnt, w_nextBrCnt;
  logic        w_exBubble;
  logic        w_exRegwrite;
  logic        r_exMemwrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_brCnt <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_brCnt <= w_nextBrCnt;
    end
  end

  // RUN and a released DSTALL behave alike: a branch decoded on release still opens its shadow.
  always_comb begin
    w_nextState = r_state;
    w_nextBrCnt = r_brCnt;
    w_exBubble  = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst) begin
      if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        w_exBubble  = 1'b1;
        w_nextState = RUN;
        w_nextBrCnt = 2'd0;
      end else begin
        unique case (r_state)
          RUN, DSTALL: begin
            if (!stall_n) begin
              pc_hold     = 1'b1;
              ifid_hold   = 1'b1;
              w_exBubble  = 1'b1;
              w_nextState = DSTALL;
            end else if (id_valid && id_is_branch) begin
              w_nextState = BSTALL;
              w_nextBrCnt = 2'(BR_BUBBLES);
            end else begin
              w_nextState = RUN;
            end
          end
          BSTALL: begin
            ifid_flush  = 1'b1;
            w_exBubble  = 1'b1;
            w_nextBrCnt = r_brCnt - 2'd1;
            if (r_brCnt <= 2'd1) begin
              w_nextState = RUN;
              w_nextBrCnt = 2'd0;
            end
          end
          default: begin
            w_nextState = RUN;
            w_nextBrCnt = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_exBubble) r_exMemwrite <= 1'b0;
    else                   r_exMemwrite <= id_memwrite;
  end

  assign ex_memwrite = r_exMemwrite;

  hazard_stage_reg #(.REG_W(REG_W)) u_exStage (
    .clk        (clk),
    .rst        (rst),
    .i_bubble   (w_exBubble),
    .i_valid    (id_valid),
    .i_dst      (id_dst),
    .i_regwrite (id_regwrite),
    .o_valid    (ex_valid),
    .o_dst      (ex_dst),
    .o_regwrite (w_exRegwrite)
  );

  hazard_stage_reg #(.REG_W(REG_W)) u_memStage (
    .clk        (clk),
    .rst        (rst),
    .i_bubble   (1'b0),
    .i_valid    (ex_valid),
    .i_dst      (ex_dst),
    .i_regwrite (w_exRegwrite),
    .o_valid    (mem_valid),
    .o_dst      (mem_dst),
    .o_regwrite (mem_regwrite)
  );

  hazard_stage_reg #(.REG_W(REG_W)) u_wbStage (
    .clk        (clk),
    .rst        (rst),
    .i_bubble   (1'b0),
    .i_valid    (mem_valid),
    .i_dst      (mem_dst),
    .i_regwrite (mem_regwrite),
    .o_valid    (wb_valid),
    .o_dst      (wb_dst),
    .o_regwrite (wb_regwrite)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] r_stallCnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stallCnt <= 16'd0;
    else if ((pc_hold || ifid_flush) && (r_stallCnt != 16'hFFFF))
      r_stallCnt <= r_stallCnt + 16'd1;
  end

  assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Self-checking bench for hazard_bubble_ctrl: directed scenarios then random
// traffic, compared against a pipeline-slot model. Honours HAZARD_STALL_CNT_EN.
module tb_hazard_bubble_ctrl;

  localparam int BR    = 2;
  localparam int REG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_dst;
  logic             id_regwrite;
  logic             id_memwrite;
  logic             id_is_branch;
  logic             stall_n;
  logic             ex_br_taken;
  logic             pc_hold, ifid_hold, ifid_flush;
  logic [REG_W-1:0] ex_dst, mem_dst, wb_dst;
  logic             ex_valid, mem_valid, wb_valid;
  logic             mem_regwrite, wb_regwrite, ex_memwrite;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_bubble_ctrl #(.BR_BUBBLES(BR), .REG_W(REG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memwrite  (id_memwrite),
    .id_is_branch (id_is_branch),
    .stall_n      (stall_n),
    .ex_br_taken  (ex_br_taken),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .ex_dst       (ex_dst),
    .mem_dst      (mem_dst),
    .wb_dst       (wb_dst),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .ex_memwrite  (ex_memwrite)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // Model: each pipeline slot is what the instruction looks like there;
  // shadowLeft is how many wrong-path fetch cycles remain behind a branch.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             rw;
    logic             mw;
  } slot_t;

  slot_t       mEx, mMem, mWb;
  int          shadowLeft;
  int unsigned mStallCnt;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [REG_W-1:0] d,
                               input bit rw, input bit mw, input bit br,
                               input bit sn, input bit tk);
    bit    expHold, expFlush, squash;
    slot_t incoming;
    @(negedge clk);
    rst = r; id_valid = v; id_dst = d; id_regwrite = rw; id_memwrite = mw;
    id_is_branch = br; stall_n = sn; ex_br_taken = tk;
    #1;
    expFlush = !r && (tk || shadowLeft > 0);
    expHold  = !r && !tk && (shadowLeft == 0) && !sn;
    checkOutput("pc_hold",      16'(pc_hold),      16'(expHold));
    checkOutput("ifid_hold",    16'(ifid_hold),    16'(expHold));
    checkOutput("ifid_flush",   16'(ifid_flush),   16'(expFlush));
    checkOutput("ex_valid",     16'(ex_valid),     16'(mEx.valid));
    checkOutput("ex_dst",       16'(ex_dst),       16'(mEx.dst));
    checkOutput("ex_memwrite",  16'(ex_memwrite),  16'(mEx.mw));
    checkOutput("mem_valid",    16'(mem_valid),    16'(mMem.valid));
    checkOutput("mem_dst",      16'(mem_dst),      16'(mMem.dst));
    checkOutput("mem_regwrite", 16'(mem_regwrite), 16'(mMem.rw));
    checkOutput("wb_valid",     16'(wb_valid),     16'(mWb.valid));
    checkOutput("wb_dst",       16'(wb_dst),       16'(mWb.dst));
    checkOutput("wb_regwrite",  16'(wb_regwrite),  16'(mWb.rw));
`ifdef HAZARD_STALL_CNT_EN
    checkOutput("stall_cnt",    stall_cnt,         16'(mStallCnt));
`endif
    @(posedge clk);
    if (r) begin
      mEx = '0; mMem = '0; mWb = '0; shadowLeft = 0; mStallCnt = 0;
    end else begin
      if ((expHold || expFlush) && mStallCnt < 32'hFFFF) mStallCnt++;
      squash   = tk || (shadowLeft > 0) || !sn;
      incoming = squash ? slot_t'(0) : slot_t'{v, d, rw, mw};
      if (tk)                  shadowLeft = 0;
      else if (shadowLeft > 0) shadowLeft = shadowLeft - 1;
      else if (sn && v && br)  shadowLeft = BR;
      else                     shadowLeft = 0;
      mWb = mMem; mMem = mEx; mEx = incoming;
    end
  endtask

  initial begin
    mEx = '0; mMem = '0; mWb = '0; shadowLeft = 0; mStallCnt = 0;
    rst = 1'b1; id_valid = 1'b1; id_dst = 3'd6; id_regwrite = 1'b1; id_memwrite = 1'b0;
    id_is_branch = 1'b0; stall_n = 1'b1; ex_br_taken = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] reset");
    applyStimulus(1, 1, 3'd6, 1, 0, 0, 1, 0);

    $display("[TB] load-use");
    applyStimulus(0, 1, 3'd3, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 3'd4, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 3'd4, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 3'd4, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1, 0);

    $display("[TB] branch shadow");
    applyStimulus(0, 1, 3'd7, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 3'd2, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd2, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 3'd5, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1, 0);

    $display("[TB] taken flush during data stall");
    applyStimulus(0, 1, 3'd1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd1, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd1, 1, 0, 0, 1, 0);

    $display("[TB] back-to-back stall then branch");
    applyStimulus(0, 1, 3'd2, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 3'd2, 1, 0, 1, 1, 0);
    applyStimulus(0, 1, 3'd3, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 3'd3, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 3'd3, 1, 0, 0, 1, 0);

    $display("[TB] reset mid-stall");
    applyStimulus(0, 1, 3'd5, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 3'd5, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd5, 1, 0, 0, 1, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(39) == 0),
                    ($urandom_range(3) != 0),
                    REG_W'($urandom),
                    1'($urandom),
                    1'($urandom),
                    ($urandom_range(4) == 0),
                    ($urandom_range(3) != 0),
                    ($urandom_range(9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_bubble_ctrl.md
Name: hazard_bubble_ctrl

Overview:
- Producer side of the decode-stage hazard check. Tracks destination register, valid flag and write-enable for every instruction in EX, MEM and WB, and feeds these to the hazard comparator.
- Consumes the comparator's active-low stall request and the branch-resolution outcome.
- Drives PC/IF-ID hold, injects bubbles into EX, and squashes wrong-path instructions.
- Sits between the decode stage and the ID/EX pipeline register.

Parameters:
- BR_BUBBLES, 2, number of bubble cycles inserted after a decoded branch until it resolves (1..3).
- REG_W, 3, register-specifier width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a real (non-NOP) instruction.
- id_dst  in  REG_W  decode destination register.
- id_regwrite  in  1  decode instruction writes the register file.
- id_memwrite  in  1  decode instruction is a store.
- id_is_branch  in  1  decode instruction is a branch or jump.
- stall_n  in  1  hazard request from comparator; low = insert NOP.
- ex_br_taken  in  1  branch in EX resolved taken; squash younger instructions.
- pc_hold  out  1  freeze the PC.
- ifid_hold  out  1  freeze the IF/ID register.
- ifid_flush  out  1  load NOP (16'h0800) into IF/ID.
- ex_dst, mem_dst, wb_dst  out  REG_W  tracked destination registers.
- ex_valid, mem_valid, wb_valid  out  1  high = real instruction; low = bubble.
- mem_regwrite, wb_regwrite  out  1  tracked register-write enables.
- ex_memwrite  out  1  EX holds a store.

Behaviour:
- Single clock domain. rst is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values:
  - All *_valid = 0, all *_dst = 0, all *_regwrite = 0, ex_memwrite = 0.
  - FSM = RUN, bubble counter = 0.
  - pc_hold = ifid_hold = ifid_flush = 0.
- Shift: each cycle MEM<=EX and WB<=MEM (dst, valid, regwrite). EX loads decode fields, or a bubble (valid = 0, regwrite = 0, memwrite = 0, dst = 0).
- FSM states: RUN, DSTALL, BSTALL.
- RUN:
  - If stall_n = 0: EX gets a bubble; pc_hold = ifid_hold = 1 combinationally in the same cycle; next state DSTALL.
  - Else if id_valid & id_is_branch: the branch enters EX normally; counter <= BR_BUBBLES; next state BSTALL.
  - Else: normal advance.
- DSTALL:
  - Holds, and keeps inserting bubbles, while stall_n = 0.
  - On the first cycle with stall_n = 1: decode advances into EX; next state RUN.
- BSTALL:
  - pc_hold = 0, ifid_flush = 1. EX gets a bubble every cycle. Counter decrements.
  - At counter = 1 the next state is RUN.
  - A data stall from the flushed NOP is ignored: stall_n is a don't-care here.
- Flush:
  - ex_br_taken = 1 in any state forces ifid_flush = 1 and an EX bubble.
  - Next state is RUN and the counter is cleared.
- Priority: rst > ex_br_taken > stall_n = 0 > branch entry.
- Outputs are combinational in the FSM state plus stall_n. There is 0-cycle latency from stall_n low to pc_hold high.
- A stall never removes an instruction already in EX/MEM/WB; the older instructions drain.
- Reset asserted mid-stall: outputs return to reset values on the next edge. No bubble is left pending.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], counting cycles with pc_hold | ifid_flush.
  - Saturates at 16'hFFFF. Cleared by rst.
- When undefined: the port and counter are absent, and there is no behavioural change otherwise.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN = 2'd0, DSTALL = 2'd1, BSTALL = 2'd2.
  - NOP_INST = 16'h0800.
  - REG_W default.
- One natural sub-module, hazard_stage_reg: the per-stage {valid, dst, regwrite} register with a bubble-load input. It is instantiated three times (EX, MEM, WB).

Test Plan:
- Reset: hold rst for 2 cycles with id_valid = 1 -> all valids 0, pc_hold = 0, ifid_flush = 0, state RUN.
- Load-use: id_dst = 3 with regwrite = 1, then stall_n = 0 for 2 cycles -> pc_hold = ifid_hold = 1 for those 2 cycles; bubbles appear in EX then MEM; ex_dst = 3 advances to mem_dst = 3 then wb_dst = 3.
- Branch: id_is_branch = 1 with BR_BUBBLES = 2 -> ifid_flush = 1 for exactly 2 cycles; ex_valid = 0 for 2 cycles after the branch; return to RUN.
- Taken flush during DSTALL: ex_br_taken = 1 with stall_n = 0 -> ifid_flush = 1, pc_hold = 0 that cycle, next state RUN.
- Back-to-back: stall_n pulses low, then a branch on the first RUN cycle -> one bubble, then the branch enters EX, then 2 flush cycles.
- With HAZARD_STALL_CNT_EN defined: after the load-use scenario (2) plus the branch scenario (2) -> stall_cnt = 4; after rst -> 0.
